// File: rtl/sipo_rx_reg_pkg.sv
// rtl/sipo_rx_reg_pkg.sv - shared constants and output-buffer state type for sipo_rx_reg
package sipo_rx_reg_pkg;

  localparam int SIPO_WIDTH = 8;
  localparam int SIPO_CNT_W = $clog2(SIPO_WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/sipo_rx_reg_if.sv
// rtl/sipo_rx_reg_if.sv - serial-in / word-out handshake bundle for sipo_rx_reg
interface sipo_rx_reg_if
  import sipo_rx_reg_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input logic clk
);

  logic                     clr;
  logic                     in_valid;
  logic                     in_bit;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(WIDTH)-1:0] bit_cnt;
  logic                     busy;
  logic                     overflow;

  modport master (
    input  clk,
    output clr, in_valid, in_bit, out_ready,
    input  out_data, out_valid, bit_cnt, busy, overflow
  );

  modport slave (
    input  clk,
    input  clr, in_valid, in_bit, out_ready,
    output out_data, out_valid, bit_cnt, busy, overflow
  );

endinterface

// File: rtl/sipo_rx_reg_rx_bit_counter.sv
// rtl/sipo_rx_reg_rx_bit_counter.sv - modulo-WIDTH bit counter with enable, sync clear and terminal flag
module rx_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc;

  assign tc = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc;

endmodule

// File: rtl/sipo_rx_reg.sv
// rtl/sipo_rx_reg.sv - MSB-first serial-to-parallel receiver with a one-word output buffer
module sipo_rx_reg
  import sipo_rx_reg_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     busy,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  // The final bit of a word completes it directly, so only WIDTH-1 bits are stored.
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-2:0] shift_d;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             complete;
  logic [WIDTH-1:0] word;

  out_state_e       state_q;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;

  rx_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (clr),
    .en_i  (in_valid),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign complete = in_valid && !clr && tc;
  assign word     = {shift_q, in_bit};

  always_comb begin
    shift_d = shift_q;
    if (clr) begin
      shift_d = '0;
    end else if (in_valid) begin
      shift_d = word[WIDTH-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // clr never coincides with completion, so overflow set and clear cannot collide.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (clr) begin
        ovf_q <= 1'b0;
      end
      case (state_q)
        EMPTY: begin
          if (complete) begin
            data_q  <= word;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            if (out_ready) begin
              data_q <= word;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == FULL);
  assign bit_cnt   = cnt;
  assign busy      = (cnt != '0);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sipo_rx_reg.sv
// tb/tb_sipo_rx_reg.sv - directed self-checking bench for sipo_rx_reg
module tb_sipo_rx_reg;
  import sipo_rx_reg_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;

  sipo_rx_reg_if #(.WIDTH(8)) bus (.clk(clk));

  sipo_rx_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (bus.clr),
    .in_valid  (bus.in_valid),
    .in_bit    (bus.in_bit),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .bit_cnt   (bus.bit_cnt),
    .busy      (bus.busy),
    .overflow  (bus.overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives bits from b[7] down to b[lo]; inputs change and are checked at negedges.
  task automatic send_bits(input logic [7:0] b, input int lo, input bit gap);
    for (int i = 7; i >= lo; i--) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = b[i];
      @(negedge clk);
      if (gap) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.out_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({bus.out_data, bus.out_valid, bus.bit_cnt, bus.busy, bus.overflow} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%h v=%b cnt=%0d busy=%b ovf=%b, want all 0",
               bus.out_data, bus.out_valid, bus.bit_cnt, bus.busy, bus.overflow);
    end
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b0;
    send_bits(8'h55, 1, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.bit_cnt !== 3'd7 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_partial: got v=%b cnt=%0d busy=%b, want v=0 cnt=7 busy=1",
               bus.out_valid, bus.bit_cnt, bus.busy);
    end
    bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1 || bus.bit_cnt !== 3'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_word: got data=%h v=%b cnt=%0d busy=%b, want data=55 v=1 cnt=0 busy=0",
               bus.out_data, bus.out_valid, bus.bit_cnt, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_hold: got data=%h v=%b, want data=55 v=1", bus.out_data, bus.out_valid);
    end
    drain();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h55) begin
      n_err++;
      $display("FAIL basic_drain: got v=%b data=%h, want v=0 data=55", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    send_bits(8'h55, 0, 1'b0);
    n_cmp++;
    if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got data=%h v=%b, want data=55 v=1", bus.out_data, bus.out_valid);
    end
    send_bits(8'hAA, 0, 1'b0);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'hAA || bus.out_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got data=%h v=%b ovf=%b, want data=aa v=1 ovf=0",
               bus.out_data, bus.out_valid, bus.overflow);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    // Held word accepted on the very edge the next word completes.
    send_bits(8'h12, 0, 1'b0);
    send_bits(8'h34, 1, 1'b0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_bit = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h34 || bus.out_valid !== 1'b1 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_replace: got data=%h v=%b ovf=%b, want data=34 v=1 ovf=0",
               bus.out_data, bus.out_valid, bus.overflow);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_empty: got v=%b, want v=0", bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    send_bits(8'h55, 0, 1'b0);
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_early: got ovf=%b, want 0", bus.overflow);
    end
    send_bits(8'h0F, 0, 1'b0);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1 || bus.overflow !== 1'b1 || bus.bit_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL ovf_drop: got data=%h v=%b ovf=%b cnt=%0d, want data=55 v=1 ovf=1 cnt=0",
               bus.out_data, bus.out_valid, bus.overflow, bus.bit_cnt);
    end
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
      n_err++;
      $display("FAIL ovf_clr: got ovf=%b v=%b data=%h, want ovf=0 v=1 data=55",
               bus.overflow, bus.out_valid, bus.out_data);
    end
    drain();
  endtask

  task automatic test_clr_gap();
    send_bits(8'hE0, 5, 1'b0);
    n_cmp++;
    if (bus.bit_cnt !== 3'd3 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL clr_partial: got cnt=%0d busy=%b, want cnt=3 busy=1", bus.bit_cnt, bus.busy);
    end
    bus.clr = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.bit_cnt !== 3'd0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_discard: got cnt=%0d busy=%b v=%b, want cnt=0 busy=0 v=0",
               bus.bit_cnt, bus.busy, bus.out_valid);
    end
    send_bits(8'hF0, 0, 1'b1);
    n_cmp++;
    if (bus.out_data !== 8'hF0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_word: got data=%h v=%b busy=%b, want data=f0 v=1 busy=0",
               bus.out_data, bus.out_valid, bus.busy);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_bits(8'h99, 0, 1'b0);
    send_bits(8'hFF, 3, 1'b0);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.bit_cnt !== 3'd5 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h99) begin
      n_err++;
      $display("FAIL rst_pre: got cnt=%0d v=%b data=%h, want cnt=5 v=1 data=99",
               bus.bit_cnt, bus.out_valid, bus.out_data);
    end
    rstn = 1'b0; bus.clr = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    @(negedge clk);
    rstn = 1'b1; bus.clr = 1'b0; bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_data, bus.out_valid, bus.bit_cnt, bus.busy, bus.overflow} !== 14'd0) begin
      n_err++;
      $display("FAIL rst_mid: got data=%h v=%b cnt=%0d busy=%b ovf=%b, want all 0",
               bus.out_data, bus.out_valid, bus.bit_cnt, bus.busy, bus.overflow);
    end
    send_bits(8'h3C, 0, 1'b0);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h3C || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_after: got data=%h v=%b, want data=3c v=1", bus.out_data, bus.out_valid);
    end
    drain();
  endtask

  task automatic test_loopback();
    logic [7:0] lsr;
    lsr = 8'b01010101;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = lsr[7];
      @(negedge clk);
      lsr = {lsr[6:0], 1'b0};
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL loopback: got data=%h v=%b, want data=55 v=1", bus.out_data, bus.out_valid);
    end
    drain();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_clr_gap();
    test_reset_mid();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_rx_reg.md
SIPO_RX_REG -- requirements
Module: sipo_rx_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, word length in bits (>=2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rstn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port: clr  input  1  synchronous frame resync; discards the partial word and clears overflow.
REQ-005 SHALL have port: in_valid  input  1  in_bit carries a valid serial bit this cycle.
REQ-006 SHALL have port: in_bit  input  1  serial data, MSB first (matches the MSB-out order of lshift_reg).
REQ-007 SHALL have port: out_data  output  WIDTH  last completed word.
REQ-008 SHALL have port: out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts out_data when high with out_valid at the clk edge.
REQ-010 SHALL have port: bit_cnt  output  $clog2(WIDTH)  bits received in the current partial word.
REQ-011 SHALL have port: busy  output  1  high when bit_cnt != 0.
REQ-012 SHALL have port: overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 SHALL shift on each edge with in_valid=1 as follows: shift_q <= {shift_q[WIDTH-2:0], in_bit}; bit_cnt increments.
REQ-014 SHALL hold shift_q and bit_cnt on edges with in_valid=0; gaps of any length are allowed between bits.
REQ-015 SHALL treat an edge with in_valid=1 and bit_cnt=WIDTH-1 as word completion: the completed word is {shift_q[WIDTH-2:0], in_bit}, and bit_cnt wraps to 0.
REQ-016 SHALL implement the output buffer as a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL, in EMPTY on completion, load out_data and go to FULL; out_valid rises one cycle after the edge that sampled the last bit.
REQ-018 SHALL, in FULL with out_ready=1 and no completion, go to EMPTY; out_data is held.
REQ-019 SHALL, in FULL with out_ready=1 on a completion edge, load the new word and stay in FULL, so back-to-back words lose no cycle.
REQ-020 SHALL, in FULL with out_ready=0 on a completion edge, keep out_data unchanged, drop the new word, set overflow=1, and still wrap bit_cnt to 0.
REQ-021 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, when clr=1, zero shift_q and bit_cnt, clear overflow, and discard any in_valid bit in that cycle; clr does not affect out_valid or out_data.
REQ-023 SHALL ignore out_ready while in EMPTY.

Reset
REQ-024 SHALL, with rstn=0 at a clk edge, set shift_q=0, bit_cnt=0, out_data=0, out_valid=0, overflow=0, busy=0; reset overrides clr and in_valid.
REQ-025 SHALL discard a partial word and any held word on reset asserted mid-operation; the first bit after rstn rises starts a fresh word.

Structure
REQ-026 SHALL place in the shared package: the default WIDTH constant, the count-width constant $clog2(WIDTH), and the output FSM state enum {EMPTY, FULL}.
REQ-027 SHALL use one sub-module, rx_bit_counter (modulo-WIDTH counter with enable, sync clear and a terminal-count flag); all other logic is in sipo_rx_reg.

Verification
REQ-028 SHALL cover: rstn low 5 cycles, then bits 0,1,0,1,0,1,0,1 with in_valid=1 and out_ready=0 -> out_data=8'h55, out_valid=1 one cycle after the 8th bit, bit_cnt=0.
REQ-029 SHALL cover: out_ready=1, bits for 8'h55 then 8'hAA contiguous -> two out_valid words, 8'h55 then 8'hAA, overflow=0.
REQ-030 SHALL cover: out_ready=0, 8'h55 then 8'h0F -> out_data stays 8'h55, overflow=1 after the 16th bit; then clr -> overflow=0 and out_valid stays 1.
REQ-031 SHALL cover: 3 bits then clr, then bits for 8'hF0 with in_valid toggling every other cycle -> out_data=8'hF0, busy=0 after completion.
REQ-032 SHALL cover: rstn=0 after 5 bits and with a word held -> all outputs 0 next cycle; then 8'h3C received correctly.
REQ-033 SHALL cover: loopback from lshift_reg loaded with 8'b01010101 and shifting MSB-out, with in_valid=1 for 8 cycles -> out_data=8'h55.
